// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for serial_add_sub: start request with operands in, busy/done and result out.
// master drives the request side, slave is the arithmetic unit.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, LSB-first through one full-adder cell; done pulses WIDTH+1 cycles after start.
// start is ignored while busy; results hold until the next completion.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    count;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             bit_s;
    logic             bit_c;
    logic             last_bit;
    logic             load;
    logic             busy_c;
    logic             done_c;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        bit_s     = shift_a[0] ^ shift_b[0] ^ carry;
        bit_c     = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
        last_bit  = (count == LAST);
        acc_nxt   = (acc >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
        unique case (state)
            IDLE, DONE: begin
                done_c = (state == DONE);
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            count   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1 - borrow_in, so the initial carry is the inverted borrow.
            shift_a <= bus.a;
            shift_b <= bus.sub ? ~bus.b : bus.b;
            carry   <= bus.cin ^ bus.sub;
            acc     <= '0;
            count   <= '0;
        end else if (state == RUN) begin
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            acc     <= acc_nxt;
            carry   <= bit_c;
            count   <= count + CW'(1);
            if (last_bit) begin
                // carry still holds the carry into the MSB on this edge.
                sum_q  <= acc_nxt;
                cout_q <= bit_c;
                ovf_q  <= carry ^ bit_c;
            end
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
